// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one shared full-adder cell walks a WIDTH-bit operand pair LSB first.
// Latency: start accepted at E0, result and one-cycle done at E0+WIDTH, idle again at E0+WIDTH+1.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy or done.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] shift_s_nxt;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             unused_lsb;

    full_adder u_fa (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (carry_reg),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    // The adder's sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
    generate
        if (WIDTH == 1) begin : g_single
            assign shift_s_nxt = fa_sum;
        end else begin : g_multi
            assign shift_s_nxt = {fa_sum, shift_s[WIDTH-1:1]};
        end
    endgenerate

    // The accumulator's LSB is always shifted out before it is ever read.
    assign unused_lsb = shift_s[0];

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_a   <= '0;
            shift_b   <= '0;
            shift_s   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_a   <= a;
                        shift_b   <= b;
                        carry_reg <= carryIn;
                        shift_s   <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    shift_s   <= shift_s_nxt;
                    shift_a   <= shift_a >> 1;
                    shift_b   <= shift_b >> 1;
                    carry_reg <= fa_cout;
                    cnt       <= cnt + CNT_W'(1);
                    // Result registers only move on the final bit so they stay stable across a run.
                    if (last_bit) begin
                        sum_q   <= shift_s_nxt;
                        carry_q <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign sum      = sum_q;
    assign carryOut = carry_q;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed/randomized bench for serial_adder_controller at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer addition of the operands applied on each accepting edge.

module tb_serial_adder_controller;

    logic       clk = 1'b0;
    logic       reset;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int vectors = 0;
    int errors  = 0;

    logic [8:0] last_exp8;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder_controller #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .carryIn  (cin8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .carryOut (cout8)
    );

    serial_adder_controller #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .a        (a1),
        .b        (b1),
        .carryIn  (cin1),
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .carryOut (cout1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation from idle, checking every cycle of the latency window.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [8:0] exp;
        exp    = 9'(ta) + 9'(tb) + 9'(tc);
        a8     = ta;
        b8     = tb;
        cin8   = tc;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        chk("op_busy_e0", 16'(busy8), 16'd1);
        for (int k = 1; k < 8; k++) begin
            start8 = 1'($urandom);
            tick();
            chk("op_busy_run", 16'({busy8, done8}), 16'b10);
            chk("op_sum_hold", 16'({cout8, sum8}), 16'(last_exp8));
        end
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("op_done", 16'({busy8, done8}), 16'b01);
        chk("op_result", 16'({cout8, sum8}), 16'(exp));
        last_exp8 = exp;
        tick();
        chk("op_idle", 16'({busy8, done8}), 16'b00);
        chk("op_result_held", 16'({cout8, sum8}), 16'(exp));
    endtask

    initial begin
        logic [8:0] exp;
        logic [1:0] exp1;
        reset  = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
        last_exp8 = '0;
        tick();
        tick();
        chk("rst_busy8", 16'(busy8), 16'd0);
        chk("rst_done8", 16'(done8), 16'd0);
        chk("rst_sum8", 16'({cout8, sum8}), 16'd0);
        chk("rst_out1", 16'({busy1, done1, cout1, sum1}), 16'd0);
        reset = 1'b0;
        tick();

        op8(8'h5A, 8'h3C, 1'b0);
        chk("dir_5a_3c", 16'(last_exp8), 16'h096);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // start held high with operands changing every cycle: acceptances every 10 edges.
        for (int n = 0; n < 40; n++) begin
            start8 = 1'b1;
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            cin8   = 1'($urandom);
            if (n % 10 == 0) begin
                exp_q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            end
            tick();
            if (n % 10 == 8) begin
                exp = exp_q.pop_front();
                chk("hold_done", 16'({busy8, done8}), 16'b01);
                chk("hold_result", 16'({cout8, sum8}), 16'(exp));
                last_exp8 = exp;
            end else begin
                chk("hold_state", 16'({busy8, done8}), (n % 10 < 8) ? 16'b10 : 16'b00);
                chk("hold_sum_stable", 16'({cout8, sum8}), 16'(last_exp8));
            end
        end
        start8 = 1'b0;
        tick();
        chk("hold_end_idle", 16'({busy8, done8}), 16'b00);

        // Abort at the fourth RUN cycle with an asynchronous reset.
        a8     = 8'hC3;
        b8     = 8'h7E;
        cin8   = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_busy", 16'(busy8), 16'd1);
        chk("abort_pre_sum", 16'({cout8, sum8}), 16'(last_exp8));
        reset = 1'b1;
        #1;
        chk("abort_sum", 16'({cout8, sum8}), 16'd0);
        chk("abort_busy_done", 16'({busy8, done8}), 16'b00);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        last_exp8 = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("abort_no_done", 16'({busy8, done8, cout8, sum8}), 16'd0);
        end
        op8(8'h10, 8'h20, 1'b0);
        chk("post_reset_30", 16'(last_exp8), 16'h030);

        // WIDTH=1 exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            a1     = 1'(i);
            b1     = 1'(i >> 1);
            cin1   = 1'(i >> 2);
            exp1   = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1     = ~a1;
            b1     = ~b1;
            chk("w1_busy", 16'({busy1, done1}), 16'b10);
            tick();
            chk("w1_done", 16'({busy1, done1}), 16'b01);
            chk("w1_result", 16'({cout1, sum1}), 16'(exp1));
            tick();
            chk("w1_idle", 16'({busy1, done1}), 16'b00);
            chk("w1_held", 16'({cout1, sum1}), 16'(exp1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
